// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage; owns the architectural HI/LO registers.
// Latency: MULT/MULTU/DIV/DIVU take XLEN+2 cycles from start to done; divide-by-zero takes 2; MTHI/MTLO take 1.
// Backpressure: busy stalls upstream; start is ignored while busy, and flush aborts an in-flight op with no done.
// Ports: clk/reset (sync, active-high); start/op/operand_a/operand_b request; flush squash;
//        busy stall request; done completion pulse; div_by_zero sticky status; hi/lo registers.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;
  typedef enum logic [1:0] {K_MUL, K_DIV, K_DBZ} kind_t;

  state_t          state, state_nxt;
  kind_t           kind;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc_hi, acc_lo, opb;
  logic            neg_res, neg_rem;

  // Request decode; only meaningful in IDLE without a coincident flush.
  logic accept, op_mul, op_div, op_sgn, op_mthi, op_mtlo, b_zero;
  assign accept  = (state == S_IDLE) && start && !flush;
  assign op_mul  = (op[2:1] == 2'b00);
  assign op_div  = (op[2:1] == 2'b01);
  assign op_sgn  = !op[0];
  assign op_mthi = (op == 3'd4);
  assign op_mtlo = (op == 3'd5);
  assign b_zero  = (operand_b == '0);

  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  assign sign_a = op_sgn && operand_a[XLEN-1];
  assign sign_b = op_sgn && operand_b[XLEN-1];
  assign abs_a  = sign_a ? -operand_a : operand_a;
  assign abs_b  = sign_b ? -operand_b : operand_b;

  // Shift-add step: acc_lo holds the remaining multiplier bits and receives
  // the low product bits as they shift out of the adder.
  logic [XLEN:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);

  // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts the
  // dividend out at the top and the quotient bits in at the bottom.
  logic [XLEN:0] div_shift, div_diff;
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  // Sign fix-up applied in FINISH.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = neg_res ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && op_mul)      state_nxt = S_MUL;
        else if (accept && op_div) state_nxt = b_zero ? S_FINISH : S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush)           state_nxt = S_IDLE;
        else if (cnt == '0)  state_nxt = S_FINISH;
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      kind        <= K_MUL;
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opb         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_mul || op_div) begin
              cnt     <= CW'(XLEN-1);
              opb     <= abs_b;
              neg_res <= sign_a ^ sign_b;
              neg_rem <= sign_a;
              if (op_mul) begin
                kind   <= K_MUL;
                acc_hi <= '0;
                acc_lo <= abs_a;
              end else if (b_zero) begin
                // Preloaded with the architectural divide-by-zero result.
                kind   <= K_DBZ;
                acc_hi <= operand_a;
                acc_lo <= '1;
              end else begin
                kind   <= K_DIV;
                acc_hi <= '0;
                acc_lo <= abs_a;
              end
            end else if (op_mthi) begin
              hi   <= operand_a;
              done <= 1'b1;
            end else if (op_mtlo) begin
              lo   <= operand_a;
              done <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[XLEN:1];
          acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          cnt    <= cnt - 1'b1;
        end
        S_DIV: begin
          if (!div_diff[XLEN]) begin
            acc_hi <= div_diff[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
        end
        S_FINISH: begin
          if (!flush) begin
            done <= 1'b1;
            case (kind)
              K_MUL: begin
                hi <= prod_fix[2*XLEN-1:XLEN];
                lo <= prod_fix[XLEN-1:0];
              end
              K_DIV: begin
                hi          <= rem_fix;
                lo          <= quo_fix;
                div_by_zero <= 1'b0;
              end
              default: begin
                hi          <= acc_hi;
                lo          <= acc_lo;
                div_by_zero <= 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int compared = 0;
  int mismatched = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request during cycle T; returns positioned in cycle T+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Starting in cycle T+1: lat = cycle offset from T at which done is seen,
  // bcnt = number of busy cycles before it. Bounded at 100 cycles.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
  endtask

  // Counts done pulses over n cycles.
  task automatic watch(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      if (done) pulses++;
      tick();
    end
  endtask

  int lat, bcnt, pulses;

  initial begin
    // Reset state
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_dbz", 64'(div_by_zero), 64'h0);

    // MULT -3 * 5
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done(lat, bcnt);
    chk("mult_lat", 64'(lat), 64'd34);
    chk("mult_busy_cycles", 64'(bcnt), 64'd33);
    chk("mult_busy_at_done", 64'(busy), 64'h0);
    chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    tick();
    chk("mult_done_pulse", 64'(done), 64'h0);

    // MULTU max * max
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    chk("multu_lat", 64'(lat), 64'd34);
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0001);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bcnt);
    chk("div_lat", 64'(lat), 64'd34);
    chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

    // DIVU 100 / 7
    issue(3'd3, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    chk("divu_dbz", 64'(div_by_zero), 64'h0);

    // DIV overflow case
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bcnt);
    chk("divovf_lo", 64'(lo), 64'h8000_0000);
    chk("divovf_hi", 64'(hi), 64'h0);

    // DIVU by zero
    issue(3'd3, 32'h0000_1234, 32'h0);
    wait_done(lat, bcnt);
    chk("dbz_lat", 64'(lat), 64'd2);
    chk("dbz_busy_cycles", 64'(bcnt), 64'd1);
    chk("dbz_hi", 64'(hi), 64'h0000_1234);
    chk("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("dbz_flag", 64'(div_by_zero), 64'h1);

    // MULTU leaves the sticky flag alone
    issue(3'd1, 32'd2, 32'd3);
    wait_done(lat, bcnt);
    chk("mul_keeps_dbz", 64'(div_by_zero), 64'h1);
    chk("mul23_lo", 64'(lo), 64'd6);

    // DIVU 9 / 3 clears the flag
    issue(3'd3, 32'd9, 32'd3);
    wait_done(lat, bcnt);
    chk("div93_dbz", 64'(div_by_zero), 64'h0);
    chk("div93_lo", 64'(lo), 64'd3);
    chk("div93_hi", 64'(hi), 64'd0);

    // Flush mid-divide, with an ignored start while busy
    issue(3'd3, 32'd50, 32'd7);            // now at T+1
    tick(); tick(); tick(); tick();         // T+5
    op = 3'd1; operand_a = 32'd11; operand_b = 32'd13; start = 1'b1;
    tick();                                 // T+6
    start = 1'b0;
    tick(); tick(); tick(); tick();         // T+10
    flush = 1'b1;
    tick();                                 // T+11
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'h0);
    watch(40, pulses);
    chk("flush_no_done", 64'(pulses), 64'd0);
    chk("flush_hi_kept", 64'(hi), 64'd0);
    chk("flush_lo_kept", 64'(lo), 64'd3);

    // Reserved op is ignored
    issue(3'd6, 32'h5555_5555, 32'd1);
    chk("rsvd_busy", 64'(busy), 64'h0);
    watch(3, pulses);
    chk("rsvd_no_done", 64'(pulses), 64'd0);
    chk("rsvd_hi_kept", 64'(hi), 64'd0);

    // MTHI, then back-to-back MULTU issued in the done cycle
    issue(3'd4, 32'hCAFE_BABE, 32'h0);
    chk("mthi_done", 64'(done), 64'h1);
    chk("mthi_busy", 64'(busy), 64'h0);
    chk("mthi_hi", 64'(hi), 64'hCAFE_BABE);
    chk("mthi_lo_kept", 64'(lo), 64'd3);
    issue(3'd1, 32'd7, 32'd6);
    wait_done(lat, bcnt);
    chk("b2b_lat", 64'(lat), 64'd34);
    chk("b2b_hi", 64'(hi), 64'd0);
    chk("b2b_lo", 64'(lo), 64'd42);

    // MTLO
    issue(3'd5, 32'h1357_9BDF, 32'h0);
    chk("mtlo_done", 64'(done), 64'h1);
    chk("mtlo_lo", 64'(lo), 64'h1357_9BDF);

    // Reset mid-operation
    issue(3'd1, 32'd7, 32'd6);              // T+1
    tick(); tick(); tick(); tick();         // T+5
    reset = 1'b1;
    tick();                                 // T+6
    reset = 1'b0;
    chk("rstmid_hi", 64'(hi), 64'h0);
    chk("rstmid_lo", 64'(lo), 64'h0);
    chk("rstmid_busy", 64'(busy), 64'h0);
    watch(40, pulses);
    chk("rstmid_no_done", 64'(pulses), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded operation and the two register operands (PA/PB) that ID/EX presents.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers.
- Holds busy high while an operation is in flight, so hazard logic stalls IF/ID/EX.

Parameters:
- XLEN, 32, operand and HI/LO width; the iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved
- operand_a  in  XLEN  rs value (PA from ID/EX)
- operand_b  in  XLEN  rt value (PB from ID/EX)
- flush  in  1  abort any in-flight op (branch/exception squash)
- busy  out  1  operation in flight; stall request
- done  out  1  one-cycle pulse when HI/LO have been updated
- div_by_zero  out  1  sticky status for the last completed divide
- hi  out  XLEN  HI register (MFHI source)
- lo  out  XLEN  LO register (MFLO source)

Behaviour:
- Reset (clk edge with reset=1):
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE.
  - Reset dominates flush and start. Reset mid-operation discards all partial results.
- States:
  - IDLE: busy=0.
  - MUL: XLEN cycles, shift-add, 1 bit per cycle.
  - DIV: XLEN cycles, restoring division, 1 quotient bit per cycle.
  - FINISH: 1 cycle; applies sign fix-up and writes hi/lo at the end of the cycle.
  - On leaving FINISH, state=IDLE and done=1 for one cycle.
- start in IDLE at cycle T:
  - op 0–3: operands latched; state goes to MUL or DIV.
    - Signed ops latch the absolute values plus the sign bits.
    - busy=1 from T+1 through T+XLEN+1.
    - done=1 and new hi/lo are visible at T+XLEN+2, with busy=0.
  - op 4/5: hi (or lo) <= operand_a at the end of T; done=1 at T+1; busy never asserts.
  - op 6/7: ignored; no state change and no done.
- start while busy=1 is ignored. Upstream holds the instruction because of the stall.
- start in the same cycle done=1 (state is IDLE) is accepted normally, giving back-to-back operation.
- Multiply:
  - 2*XLEN product: hi=product[2XLEN-1:XLEN], lo=product[XLEN-1:0].
  - Signed ops negate the full 2*XLEN product when sign_a^sign_b.
- Divide:
  - lo=quotient, hi=remainder.
  - Signed ops negate the quotient when sign_a^sign_b; the remainder takes the sign of the dividend.
  - Overflow case -2^(XLEN-1)/-1: lo=0x80000000, hi=0. This falls out of the abs/negate flow and needs no special case.
- Divide by zero (operand_b==0 on DIV/DIVU):
  - Skip the DIV state; IDLE goes to FINISH, so done appears at T+2.
  - hi=operand_a, lo=all ones, div_by_zero=1.
- div_by_zero:
  - Set only by a completed divide-by-zero.
  - Cleared by any other completed DIV/DIVU.
  - Unchanged by MULT or MTHI/MTLO.
- flush:
  - In MUL/DIV/FINISH: return to IDLE next cycle with busy=0. hi/lo/div_by_zero are unchanged and no done is issued.
  - In IDLE: suppresses a coincident start.
- hi/lo change only on FINISH completion or MTHI/MTLO; they hold otherwise.

Test Plan:
- Reset mid-op: start MULTU 7×6, assert reset at T+5 -> hi=lo=0, busy=0 next cycle, done never pulses.
- MULT 0xFFFFFFFD (-3) × 5 at T -> busy T+1..T+33; at T+34 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2, div_by_zero=0. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> done at T+2, hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1. A following DIVU 9/3 clears div_by_zero; lo=3, hi=0.
- Start DIVU, pulse flush at T+10 -> busy=0 at T+11, hi/lo keep their prior values, no done. A second start pulsed while busy is ignored.
- MTHI 0xCAFEBABE -> hi updated, done at T+1, busy never high. A back-to-back start issued in the done cycle is accepted and completes XLEN+2 cycles later.
